ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Instruction-fetch prefetch stage. It generates sequential PCs, issues word fetches to instruction memory and buffers returned instructions in a small in-order queue. The queue feeds the decode-stage pipeline register (32-bit instruction plus PC) through a valid/ready handshake. It sits directly upstream of the IF/ID register and absorbs memory latency, decode stalls and branch redirects.

## Interface
Parameters:
- DEPTH, 4, queue entries and the maximum number of entries plus outstanding fetches; power of two, range 2..16.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address; always word aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- dec_valid  out  1  head instruction available.
- dec_ready  in  1  decode accepts the head.
- dec_inst  out  32  head instruction.
- dec_pc  out  32  PC of the head instruction.

## Operation
- Internal state:
  - fetch_pc (32 bits).
  - count, queue occupancy (0..DEPTH).
  - outst, granted requests with data not yet returned (0..DEPTH).
  - discard, stale responses still to drop (0..DEPTH).
  - PC FIFO for outstanding requests.
- Issue rule:
  - imem_req = !redirect && (count + outst + discard < DEPTH).
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4 (wraps modulo 2^32), outst += 1, and fetch_pc is pushed to the PC FIFO.
- Response handling:
  - If discard > 0, an imem_rvalid decrements discard and the data is dropped.
  - Otherwise, an imem_rvalid pushes {imem_rdata, PC FIFO head} into the queue and decrements outst.
- Dequeue: dec_valid = (count != 0); dec_valid && dec_ready pops the head.
- Simultaneous push and pop leave count unchanged. The queue never overflows because of the issue credit rule.
- Redirect (highest priority):
  - Next-cycle state: queue emptied (count = 0), PC FIFO emptied, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outst + discard − (imem_rvalid ? 1 : 0), then outst = 0.
  - An imem_rvalid arriving in the redirect cycle is always dropped.
  - A dec_ready handshake in the redirect cycle still completes; decode owns that instruction.
- imem_rvalid with outst = 0 and discard = 0 is a protocol error: it is ignored, and an assertion fires in simulation.
- Reset values (clr asynchronous):
  - fetch_pc = RESET_PC; count, outst and discard = 0.
  - imem_req = 1 in the first cycle after reset release.
  - imem_addr = RESET_PC.
  - dec_valid = 0; dec_inst = 32'h0; dec_pc = 32'h0.

## Timing
- Grant to sequential next address: imem_addr advances by 4 in the cycle after the grant.
- rvalid in cycle M gives dec_valid = 1 in cycle M+1, because the queue output is registered. There is no combinational path from imem_rdata to dec_inst.
- Redirect asserted in cycle N:
  - imem_req = 0 in cycle N.
  - In cycle N+1, imem_req is high (credit permitting) with imem_addr = redirect_pc.
  - dec_valid = 0 in cycle N+1.
- With zero-wait memory (grant every cycle, rvalid 1 cycle later) and dec_ready held high, throughput is one instruction per cycle after a 2-cycle fill.
- Decode stall (dec_ready = 0): the queue fills, then imem_req drops once count + outst = DEPTH. It reasserts in the cycle after the first pop.
- Asserting clr mid-operation aborts everything immediately. Responses to pre-reset requests are the memory's responsibility and are not tracked.

## Structure
- Shared package cpu_pkg holds:
  - XLEN = 32.
  - INST_NOP = 32'h0000_0000.
  - Default reset vector constant.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (width, depth) with flush.
  - Instantiated twice: as the 64-bit instruction/PC queue and as the 32-bit outstanding-PC FIFO.

## Test plan
- Reset with RESET_PC = 0x100, zero-wait memory, dec_ready = 1 → imem_addr sequence 0x100, 0x104, 0x108; dec_pc sequence 0x100, 0x104, … from the 3rd cycle onward, one per cycle.
- dec_ready = 0 for 10 cycles, DEPTH = 4, 1-cycle memory → exactly 4 grants, then imem_req = 0. After release, 4 pops occur in order and imem_req reasserts in the cycle after the first pop.
- 3-cycle response latency, 2 outstanding, redirect to 0x2000 → the 2 late rvalids are dropped, the next dec_pc is 0x2000, and no stale instruction reaches decode.
- Redirect coincident with rvalid and with a dec_ready pop → the popped instruction completes, the rvalid data is dropped, and discard is decremented correctly.
- fetch_pc = 0xFFFF_FFFC → the next imem_addr is 0x0000_0000.
- clr asserted while the queue is full → all outputs are at reset values in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch queue payload type.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with single-cycle flush; head word read straight from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pops of an empty FIFO are ignored; a push into a full FIFO needs a same-cycle pop.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array, no reset needed since reads are qualified by occupancy.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: sequential PC generation, credit-limited fetch issue,
// in-order response buffering toward decode, and redirect flush with stale-response drop.
module ifu_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic            clk,
    input  logic            clr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_outst;
    logic [SW-1:0]   w_inflight;
    logic            w_grant;
    logic            w_rv_tracked;
    logic            w_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_head;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    // Every queued entry, live request and stale request holds one credit.
    assign w_inflight = SW'(w_count) + SW'(w_outst) + SW'(r_discard);
    assign imem_req   = !redirect && (w_inflight < SW'(DEPTH));
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;

    // A response matches some request only if something is live or stale.
    assign w_rv_tracked = imem_rvalid && ((w_outst != '0) || (r_discard != '0));
    assign w_accept     = imem_rvalid && !redirect && (r_discard == '0) && (w_outst != '0);

    assign dec_valid    = (w_count != '0);
    assign w_pop        = dec_valid && dec_ready;
    assign w_push_entry = '{inst: imem_rdata, pc: w_pc_head};
    assign dec_inst     = dec_valid ? w_head.inst : INST_NOP;
    assign dec_pc       = dec_valid ? w_head.pc : '0;

    // Fetch address and stale-response counter; redirect converts all live requests to stale.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_discard  <= w_outst + r_discard - CW'(w_rv_tracked);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (imem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    // Instruction/PC queue feeding decode.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_inst_q (
        .clk     (clk),
        .clr     (clr),
        .i_flush (redirect),
        .i_push  (w_accept),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // PCs of granted requests awaiting data; its occupancy is the live outstanding count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_pc_q (
        .clk     (clk),
        .clr     (clr),
        .i_flush (redirect),
        .i_push  (w_grant),
        .i_wdata (r_fetch_pc),
        .i_pop   (w_accept),
        .o_rdata (w_pc_head),
        .o_count (w_outst)
    );

    // Data returned with nothing live or stale outstanding violates the memory protocol.
    assert property (@(posedge clk) disable iff (clr)
        !(imem_rvalid && (w_outst == '0) && (r_discard == '0)))
        else $error("ifu_prefetch: imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order, fixed-latency instruction memory model.
module tb_ifu_prefetch;

    logic        clk;
    logic        clr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_ent_t;

    mem_ent_t pend[$];
    int       cyc;
    int       lat;
    int       ngnt;
    int       nchk;
    int       nerr;

    ifu_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; memory answers a grant in cycle k during cycle k+lat with ~addr.
    task automatic tick();
        logic        g;
        logic        rv;
        logic [31:0] a;
        mem_ent_t    e;
        g  = imem_req && imem_gnt;
        rv = imem_rvalid;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (rv && pend.size() > 0) e = pend.pop_front();
        if (g) begin
            pend.push_back('{addr: a, due: cyc + lat});
            ngnt++;
        end
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend[0].addr;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    // Reset across one edge, then release; caller is in cycle 0 afterwards.
    task automatic do_reset();
        clr         = 1'b1;
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        dec_ready   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend.delete();
        @(posedge clk);
        #2;
        clr  = 1'b0;
        cyc  = 0;
        ngnt = 0;
        #1;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        cyc  = 0;
        ngnt = 0;
        lat  = 1;
        clr         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        dec_ready   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0000_0100);

        // Zero-wait streaming.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        #1;
        chk("t1_req_c0", 32'(imem_req), 32'd1);
        chk("t1_addr_c0", imem_addr, 32'h100);
        chk("t1_valid_c0", 32'(dec_valid), 32'd0);
        tick();
        chk("t1_addr_c1", imem_addr, 32'h104);
        chk("t1_valid_c1", 32'(dec_valid), 32'd0);
        tick();
        chk("t1_addr_c2", imem_addr, 32'h108);
        chk("t1_valid_c2", 32'(dec_valid), 32'd1);
        chk("t1_pc_c2", dec_pc, 32'h100);
        chk("t1_inst_c2", dec_inst, 32'hFFFF_FEFF);
        tick();
        chk("t1_pc_c3", dec_pc, 32'h104);
        tick();
        chk("t1_valid_c4", 32'(dec_valid), 32'd1);
        chk("t1_pc_c4", dec_pc, 32'h108);

        // Decode stall for 10 cycles fills the queue and stops issue.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b0;
        #1;
        repeat (10) tick();
        chk("t2_grants", 32'(ngnt), 32'd4);
        chk("t2_req_stall", 32'(imem_req), 32'd0);
        chk("t2_valid_stall", 32'(dec_valid), 32'd1);
        chk("t2_pc_stall", dec_pc, 32'h100);
        dec_ready = 1'b1;
        #1;
        chk("t2_req_pop_cycle", 32'(imem_req), 32'd0);
        tick();
        chk("t2_req_after_pop", 32'(imem_req), 32'd1);
        chk("t2_addr_after_pop", imem_addr, 32'h110);
        chk("t2_pc_pop2", dec_pc, 32'h104);
        tick();
        chk("t2_pc_pop3", dec_pc, 32'h108);
        tick();
        chk("t2_pc_pop4", dec_pc, 32'h10C);
        tick();
        chk("t2_pc_refill", dec_pc, 32'h110);

        // Redirect with two requests in flight at 3-cycle latency.
        do_reset();
        lat = 3; imem_gnt = 1'b1; dec_ready = 1'b1;
        #1;
        tick();
        tick();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        chk("t3_req_redirect", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("t3_req_after", 32'(imem_req), 32'd1);
        chk("t3_addr_after", imem_addr, 32'h2000);
        chk("t3_valid_after", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_no_stale", 32'(dec_valid), 32'd0);
        end
        tick();
        chk("t3_valid_new", 32'(dec_valid), 32'd1);
        chk("t3_pc_new", dec_pc, 32'h2000);
        chk("t3_inst_new", dec_inst, 32'hFFFF_DFFF);
        tick();
        chk("t3_pc_next", dec_pc, 32'h2004);

        // Redirect coinciding with a returning response and a decode pop.
        do_reset();
        lat = 2; imem_gnt = 1'b1; dec_ready = 1'b1;
        #1;
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        #1;
        chk("t4_req_redirect", 32'(imem_req), 32'd0);
        chk("t4_rvalid_coincident", 32'(imem_rvalid), 32'd1);
        chk("t4_pop_valid", 32'(dec_valid), 32'd1);
        chk("t4_pop_pc", dec_pc, 32'h100);
        tick();
        redirect = 1'b0;
        #1;
        chk("t4_valid_c4", 32'(dec_valid), 32'd0);
        chk("t4_req_c4", 32'(imem_req), 32'd1);
        chk("t4_addr_c4", imem_addr, 32'h3000);
        tick();
        chk("t4_valid_c5", 32'(dec_valid), 32'd0);
        tick();
        chk("t4_valid_c6", 32'(dec_valid), 32'd0);
        tick();
        chk("t4_valid_c7", 32'(dec_valid), 32'd1);
        chk("t4_pc_c7", dec_pc, 32'h3000);
        tick();
        chk("t4_pc_c8", dec_pc, 32'h3004);

        // Redirect to the top word (low bits set) and wrap of the fetch address.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        #1;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("t5_req_redirect", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("t5_req_after", 32'(imem_req), 32'd1);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("t5_valid_after", 32'(dec_valid), 32'd0);
        tick();
        chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
        tick();
        chk("t5_pc_top", dec_pc, 32'hFFFF_FFFC);
        chk("t5_addr_4", imem_addr, 32'h0000_0004);
        tick();
        chk("t5_pc_wrap", dec_pc, 32'h0000_0000);
        chk("t5_inst_wrap", dec_inst, 32'hFFFF_FFFF);

        // Asynchronous clear with a full queue.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b0;
        #1;
        repeat (6) tick();
        chk("t6_full_valid", 32'(dec_valid), 32'd1);
        chk("t6_full_req", 32'(imem_req), 32'd0);
        clr = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend.delete();
        #1;
        chk("t6_clr_valid", 32'(dec_valid), 32'd0);
        chk("t6_clr_inst", dec_inst, 32'h0);
        chk("t6_clr_pc", dec_pc, 32'h0);
        chk("t6_clr_addr", imem_addr, 32'h100);
        clr = 1'b0;
        #1;
        chk("t6_rel_req", 32'(imem_req), 32'd1);
        chk("t6_rel_addr", imem_addr, 32'h100);
        chk("t6_rel_valid", 32'(dec_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
